// File: rtl/config_stream_loader_pkg.sv
// rtl/config_stream_loader_pkg.sv - shared types and helpers for the config stream loader
package config_stream_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_FLUSH,
    ST_WAIT_DONE,
    ST_ERR
  } state_t;

  // Address bit0 marks the initiate word that injects the tile-enable token.
  localparam logic [31:0] CFG_ADDR_INITIATE = 32'd1;
  localparam logic [31:0] CFG_ADDR_SHIFT    = 32'd0;

  function automatic int unsigned total_words(input int unsigned stages,
                                              input int unsigned lutsize);
    return stages << lutsize;
  endfunction

endpackage

// File: rtl/config_stream_loader_if.sv
// rtl/config_stream_loader_if.sv - bitstream word stream handshake between source and loader
interface config_stream_loader_if #(
  parameter int WIDTH = 16
);

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/config_stream_loader.sv
// rtl/config_stream_loader.sv - sequences a bitstream load into the serial configuration controller
module config_stream_loader
  import config_stream_loader_pkg::*;
#(
  parameter int LUTSIZE      = 2,
  parameter int STAGES       = 3,
  parameter int WIDTH        = 16,
  parameter int DONE_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  config_stream_loader_if.slave   stream,
  output logic                    cfg_reset,
  output logic                    cfg_wren,
  output logic [31:0]             cfg_addr,
  output logic [WIDTH-1:0]        cfg_data,
  input  logic                    cfg_done_in,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [15:0]             words_loaded
);

  localparam int unsigned    TOTAL      = total_words(STAGES, LUTSIZE);
  localparam logic [15:0]    LAST_IDX   = 16'(TOTAL - 1);
  localparam int             TW         = $clog2(DONE_TIMEOUT + 1);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(DONE_TIMEOUT - 1);

  if (TOTAL > 65535 || TOTAL == 0) begin : g_bad_total
    $error("config_stream_loader: STAGES << LUTSIZE must be in 1..65535");
  end

  state_t          state;
  logic            s_ready_q;
  logic [TW-1:0]   timer;

  assign stream.s_ready = s_ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      s_ready_q    <= 1'b0;
      timer        <= '0;
      cfg_reset    <= 1'b0;
      cfg_wren     <= 1'b0;
      cfg_addr     <= '0;
      cfg_data     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      cfg_wren  <= 1'b0;
      cfg_reset <= 1'b0;
      case (state)
        ST_IDLE, ST_ERR: begin
          if (start) begin
            state        <= ST_CLR;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            cfg_reset    <= 1'b1;
          end
        end
        ST_CLR: begin
          if (cfg_done_in) begin
            state     <= ST_ERR;
            error     <= 1'b1;
            busy      <= 1'b0;
            s_ready_q <= 1'b0;
          end else begin
            state     <= ST_LOAD;
            s_ready_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          // A token leaving before the flush means the chain length is wrong.
          if (cfg_done_in) begin
            state     <= ST_ERR;
            error     <= 1'b1;
            busy      <= 1'b0;
            s_ready_q <= 1'b0;
          end else if (stream.s_valid && s_ready_q) begin
            cfg_wren     <= 1'b1;
            cfg_data     <= stream.s_data;
            cfg_addr     <= (words_loaded == 16'd0) ? CFG_ADDR_INITIATE : CFG_ADDR_SHIFT;
            words_loaded <= words_loaded + 16'd1;
            if (words_loaded == LAST_IDX) begin
              state     <= ST_FLUSH;
              s_ready_q <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          cfg_wren <= 1'b1;
          cfg_addr <= CFG_ADDR_SHIFT;
          cfg_data <= '0;
          timer    <= '0;
          state    <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (cfg_done_in) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (timer == TIMER_LAST) begin
            state <= ST_ERR;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state     <= ST_ERR;
          busy      <= 1'b0;
          error     <= 1'b1;
          s_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_stream_loader.sv
// tb/tb_config_stream_loader.sv - scoreboard bench for config_stream_loader
module tb_config_stream_loader;

  localparam int LUTSIZE = 2;
  localparam int STAGES  = 3;
  localparam int WIDTH   = 16;
  localparam int TMO     = 16;
  localparam int TOTAL   = STAGES << LUTSIZE;

  typedef struct packed {
    logic [31:0]      addr;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              cfg_done_in;
  logic              cfg_reset;
  logic              cfg_wren;
  logic [31:0]       cfg_addr;
  logic [WIDTH-1:0]  cfg_data;
  logic              busy;
  logic              done;
  logic              error;
  logic [15:0]       words_loaded;

  config_stream_loader_if #(.WIDTH(WIDTH)) stream ();

  config_stream_loader #(
    .LUTSIZE(LUTSIZE), .STAGES(STAGES), .WIDTH(WIDTH), .DONE_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stream(stream),
    .cfg_reset(cfg_reset), .cfg_wren(cfg_wren), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_done_in(cfg_done_in), .busy(busy),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   wren_cnt = 0;
  int   creset_cnt = 0;
  int   exp_idx = 0;
  exp_t exp_q[$];
  exp_t e;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: transfers push the expected cfg write, cfg_wren pops it.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      exp_idx = 0;
    end else begin
      if (cfg_reset) begin
        creset_cnt++;
        exp_idx = 0;
      end
      if (cfg_wren) begin
        wren_cnt++;
        check_eq("wren_has_expect", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("cfg_addr", 64'(cfg_addr), 64'(e.addr));
          check_eq("cfg_data", 64'(cfg_data), 64'(e.data));
        end
      end
      if (stream.s_valid && stream.s_ready) begin
        exp_q.push_back('{addr: (exp_idx == 0) ? 32'd1 : 32'd0, data: stream.s_data});
        exp_idx++;
        if (exp_idx == TOTAL) exp_q.push_back('{addr: 32'd0, data: '0});
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stream_words(input int first, input int n, input bit gap, input logic [15:0] base);
    int sent = 0;
    int cyc  = 0;
    bit phase = 1'b1;
    while (sent < n && cyc < 200) begin
      stream.s_valid = gap ? phase : 1'b1;
      stream.s_data  = base + 16'((first + sent) * 37);
      @(negedge clk);
      if (stream.s_valid && stream.s_ready) sent++;
      @(posedge clk); #1;
      phase = ~phase;
      cyc++;
    end
    stream.s_valid = 1'b0;
    check_eq("stream_sent", 64'(sent), 64'(n));
  endtask

  task automatic finish_load(input int delay);
    @(posedge clk); #1;
    repeat (delay) begin @(posedge clk); #1; end
    cfg_done_in = 1'b1;
    @(posedge clk); #1;
    cfg_done_in = 1'b0;
  endtask

  int b_w, b_r, k;

  initial begin
    reset = 1'b0; start = 1'b0; cfg_done_in = 1'b0;
    stream.s_valid = 1'b0; stream.s_data = '0;
    repeat (2) @(posedge clk); #1;
    check_eq("rst_outputs", {busy, done, error, cfg_wren, cfg_reset, stream.s_ready}, 64'd0);
    check_eq("rst_words", 64'(words_loaded), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: full-rate load
    b_w = wren_cnt; b_r = creset_cnt;
    pulse_start();
    check_eq("t1_busy", 64'(busy), 64'd1);
    stream_words(0, TOTAL, 1'b0, 16'h1100);
    finish_load(3);
    check_eq("t1_done", {done, error, busy}, 64'b100);
    check_eq("t1_words", 64'(words_loaded), 64'(TOTAL));
    check_eq("t1_wren_cnt", 64'(wren_cnt - b_w), 64'(TOTAL + 1));
    check_eq("t1_clr_cnt", 64'(creset_cnt - b_r), 64'd1);
    check_eq("t1_q_empty", 64'(exp_q.size()), 64'd0);

    // 2: toggling valid, start coincident with return to IDLE is ignored
    b_w = wren_cnt; b_r = creset_cnt;
    pulse_start();
    stream_words(0, TOTAL, 1'b1, 16'h2200);
    @(posedge clk); #1;
    cfg_done_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    cfg_done_in = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check_eq("t2_idle", {done, error, busy}, 64'b100);
    check_eq("t2_wren_cnt", 64'(wren_cnt - b_w), 64'(TOTAL + 1));
    check_eq("t2_clr_cnt", 64'(creset_cnt - b_r), 64'd1);

    // 3: done never arrives -> timeout
    pulse_start();
    check_eq("t3_done_cleared", 64'(done), 64'd0);
    stream_words(0, TOTAL, 1'b0, 16'h3300);
    @(posedge clk); #1;
    k = 0;
    while (!error && k < 40) begin @(posedge clk); #1; k++; end
    check_eq("t3_tmo_cycles", 64'(k), 64'(TMO));
    check_eq("t3_state", {done, error, busy, stream.s_ready}, 64'b0100);

    // 4: premature token exit
    b_w = wren_cnt;
    pulse_start();
    check_eq("t4_err_cleared", 64'(error), 64'd0);
    stream_words(0, 5, 1'b0, 16'h4400);
    cfg_done_in = 1'b1;
    @(posedge clk); #1;
    cfg_done_in = 1'b0;
    stream.s_valid = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check_eq("t4_state", {done, error, busy, stream.s_ready}, 64'b0100);
    check_eq("t4_wren_cnt", 64'(wren_cnt - b_w), 64'd5);
    check_eq("t4_words", 64'(words_loaded), 64'd5);
    stream.s_valid = 1'b0;

    // 5: reset mid-load, then clean reload
    pulse_start();
    stream_words(0, 7, 1'b0, 16'h5500);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_eq("t5_rst_flags", {busy, done, error, cfg_wren, cfg_reset, stream.s_ready}, 64'd0);
    check_eq("t5_rst_bus", {cfg_addr, cfg_data, words_loaded}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    b_w = wren_cnt;
    pulse_start();
    stream_words(0, TOTAL, 1'b0, 16'h5A00);
    finish_load(0);
    check_eq("t5_done", {done, error, busy}, 64'b100);
    check_eq("t5_wren_cnt", 64'(wren_cnt - b_w), 64'(TOTAL + 1));

    // 6: start during LOAD is ignored
    b_r = creset_cnt;
    pulse_start();
    stream_words(0, 6, 1'b0, 16'h6600);
    pulse_start();
    check_eq("t6_mid_words", 64'(words_loaded), 64'd6);
    check_eq("t6_mid_busy", 64'(busy), 64'd1);
    stream_words(6, TOTAL - 6, 1'b0, 16'h6600);
    finish_load(2);
    check_eq("t6_words", 64'(words_loaded), 64'(TOTAL));
    check_eq("t6_done", {done, error, busy}, 64'b100);
    check_eq("t6_clr_cnt", 64'(creset_cnt - b_r), 64'd1);
    check_eq("t6_q_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
